// File: rtl/udma_ts_event_tx.sv
// -----------------------------------------------------------------------------
// udma_ts_event_tx
//
// Purpose:
//   Timestamps asynchronous trigger events and forwards them, one at a time,
//   to a receiver in another clock domain. The handshake is toggle-encoded.
//   Each new event inverts ts_valid_async_o. ts_chid_o and ts_data_o change
//   only in the cycle of that inversion. They then stay stable for at least
//   HOLD_CYCLES cycles, which gives the receiver time to synchronize the
//   toggle and sample the payload.
//
// Ports:
//   ts_clk_i          block clock
//   rst_ni            asynchronous active-low reset
//   en_i              counter enable and trigger enable
//   cnt_clr_i         synchronous clear of the timestamp counter
//   trig_async_i      asynchronous per-channel event inputs
//   ts_valid_async_o  toggle-encoded event strobe
//   ts_chid_o         channel ID of the current event
//   ts_data_o         timestamp of the current event
//   ovf_o             sticky per-channel "event dropped" flags
//   ovf_clr_i         clears all ovf_o bits (a set in the same cycle wins)
//   busy_o            high while an event is in HOLD or any channel is pending
//
// Build option:
//   TS_TX_SATURATE_EN  When defined, the timestamp counter saturates at
//                      all-ones instead of wrapping.
// -----------------------------------------------------------------------------
module udma_ts_event_tx #(
    parameter int NB_CH         = 4,
    parameter int TS_DATA_WIDTH = 28,
    parameter int TS_CHID_WIDTH = 4,
    parameter int HOLD_CYCLES   = 16
) (
    input  logic                     ts_clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     cnt_clr_i,
    input  logic [NB_CH-1:0]         trig_async_i,
    output logic                     ts_valid_async_o,
    output logic [TS_CHID_WIDTH-1:0] ts_chid_o,
    output logic [TS_DATA_WIDTH-1:0] ts_data_o,
    output logic [NB_CH-1:0]         ovf_o,
    input  logic                     ovf_clr_i,
    output logic                     busy_o
);

    // The hold counter only has to hold HOLD_CYCLES-1.
    localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_HOLD = 1'b1;

    // Timestamp counter
    logic [TS_DATA_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;

    // Synchronizer stages plus history flop for edge detection
    logic [NB_CH-1:0] sync0_q, sync1_q, hist_q;
    logic [NB_CH-1:0] rise, rise_en;

    // Per-channel pending flags and captured timestamps
    logic [NB_CH-1:0]                     pend_q, pend_d;
    logic [NB_CH-1:0][TS_DATA_WIDTH-1:0]  cap_q, cap_d;
    logic [NB_CH-1:0]                     ovf_q, ovf_d, ovf_set;

    // Arbitration
    logic                     grant_vld;
    logic [NB_CH-1:0]         grant_oh;
    logic [TS_CHID_WIDTH-1:0] grant_idx;
    logic [TS_DATA_WIDTH-1:0] grant_data;

    // Output handshake FSM
    logic                     state_q, state_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;
    logic                     valid_q, valid_d;
    logic [TS_CHID_WIDTH-1:0] chid_q, chid_d;
    logic [TS_DATA_WIDTH-1:0] data_q, data_d;

    // ---------------- counter ----------------
    always_comb begin
`ifdef TS_TX_SATURATE_EN
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + TS_DATA_WIDTH'(1);
`else
        cnt_inc = cnt_q + TS_DATA_WIDTH'(1);
`endif
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_inc;
        end
    end

    // ---------------- edge detect ----------------
    assign rise    = sync1_q & ~hist_q;
    assign rise_en = rise & {NB_CH{en_i}};

    // ---------------- arbitration: lowest pending index wins ----------------
    always_comb begin
        grant_vld  = 1'b0;
        grant_oh   = '0;
        grant_idx  = '0;
        grant_data = '0;
        for (int i = NB_CH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                grant_vld  = 1'b1;
                grant_oh   = '0;
                grant_oh[i] = 1'b1;
                grant_idx  = TS_CHID_WIDTH'(i);
                grant_data = cap_q[i];
            end
        end
        // Grants are only issued from IDLE.
        if (state_q != STATE_IDLE) begin
            grant_vld = 1'b0;
            grant_oh  = '0;
        end
    end

    // ---------------- pending / capture / overflow ----------------
    always_comb begin
        // A rise on a channel that stays pending is dropped. The first event
        // is still queued, so the new one is reported as an overflow.
        ovf_set = rise_en & pend_q & ~grant_oh;
        pend_d  = (pend_q & ~grant_oh) | rise_en;
        cap_d   = cap_q;
        for (int i = 0; i < NB_CH; i++) begin
            if (rise_en[i] && !ovf_set[i]) begin
                cap_d[i] = cnt_q;
            end
        end
        ovf_d = (ovf_clr_i ? '0 : ovf_q) | ovf_set;
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        chid_d  = chid_q;
        data_d  = data_q;
        if (state_q == STATE_IDLE) begin
            if (grant_vld) begin
                valid_d = ~valid_q;
                chid_d  = grant_idx;
                data_d  = grant_data;
                hold_d  = HOLD_W'(HOLD_CYCLES - 1);
                state_d = STATE_HOLD;
            end
        end else begin
            if (hold_q == '0) begin
                state_d = STATE_IDLE;
            end else begin
                hold_d = hold_q - HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge ts_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            sync0_q <= '0;
            sync1_q <= '0;
            hist_q  <= '0;
            pend_q  <= '0;
            cap_q   <= '0;
            ovf_q   <= '0;
            state_q <= STATE_IDLE;
            hold_q  <= '0;
            valid_q <= 1'b0;
            chid_q  <= '0;
            data_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            sync0_q <= trig_async_i;
            sync1_q <= sync0_q;
            hist_q  <= sync1_q;
            pend_q  <= pend_d;
            cap_q   <= cap_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            chid_q  <= chid_d;
            data_q  <= data_d;
        end
    end

    assign ts_valid_async_o = valid_q;
    assign ts_chid_o        = chid_q;
    assign ts_data_o        = data_q;
    assign ovf_o            = ovf_q;
    assign busy_o           = (state_q != STATE_IDLE) | (|pend_q);

endmodule

// File: tb/tb_udma_ts_event_tx.sv
module tb_udma_ts_event_tx;
    localparam int NB_CH = 4;
    localparam int DW    = 8;
    localparam int CW    = 4;
    localparam int HOLD  = 16;

    logic             clk     = 1'b0;
    logic             rst_ni  = 1'b0;
    logic             en      = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [NB_CH-1:0] trig    = '0;
    logic             ovf_clr = 1'b0;
    logic             valid;
    logic [CW-1:0]    chid;
    logic [DW-1:0]    data;
    logic [NB_CH-1:0] ovf;
    logic             busy;

    int n_checks = 0;
    int n_err    = 0;

    logic [DW-1:0] exp_cnt   = '0;
    logic          exp_valid = 1'b0;
    logic [DW-1:0] ts_exp    = '0;

    udma_ts_event_tx #(
        .NB_CH        (NB_CH),
        .TS_DATA_WIDTH(DW),
        .TS_CHID_WIDTH(CW),
        .HOLD_CYCLES  (HOLD)
    ) dut (
        .ts_clk_i        (clk),
        .rst_ni          (rst_ni),
        .en_i            (en),
        .cnt_clr_i       (cnt_clr),
        .trig_async_i    (trig),
        .ts_valid_async_o(valid),
        .ts_chid_o       (chid),
        .ts_data_o       (data),
        .ovf_o           (ovf),
        .ovf_clr_i       (ovf_clr),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: reference counter follows the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_ni || cnt_clr) begin
            exp_cnt = '0;
        end else if (en) begin
`ifdef TS_TX_SATURATE_EN
            if (exp_cnt != '1) exp_cnt = exp_cnt + 8'd1;
`else
            exp_cnt = exp_cnt + 8'd1;
`endif
        end
        @(negedge clk);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_cnt(input logic [DW-1:0] target);
        for (int i = 0; i < 300 && exp_cnt != target; i++) tick();
    endtask

    initial begin
        // ---- reset state ----
        tick_n(2);
        check("rst_valid", 32'(valid), 0);
        check("rst_chid",  32'(chid),  0);
        check("rst_data",  32'(data),  0);
        check("rst_ovf",   32'(ovf),   0);
        check("rst_busy",  32'(busy),  0);
        rst_ni  = 1'b1;
        en      = 1'b1;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;

        // ---- single event on ch2 with the counter at 100 ----
        wait_cnt(8'd98);
        trig[2] = 1'b1;
        tick_n(3);
        check("ch2_not_early", 32'(valid), 32'(exp_valid));
        tick();
        exp_valid = ~exp_valid;
        check("ch2_toggle", 32'(valid), 32'(exp_valid));
        check("ch2_chid",   32'(chid),  2);
        check("ch2_data",   32'(data),  100);
        check("ch2_busy",   32'(busy),  1);
        trig[2] = 1'b0;
        tick_n(20);
        check("ch2_single", 32'(valid), 32'(exp_valid));
        check("ch2_stable", 32'(data),  100);
        check("ch2_idle",   32'(busy),  0);

        // ---- ch0 and ch3 together ----
        ts_exp = exp_cnt + 8'd2;
        trig   = 4'b1001;
        tick_n(4);
        exp_valid = ~exp_valid;
        check("dual_t0_valid", 32'(valid), 32'(exp_valid));
        check("dual_t0_chid",  32'(chid),  0);
        check("dual_t0_data",  32'(data),  32'(ts_exp));
        trig = '0;
        tick_n(HOLD);
        check("dual_gap_valid", 32'(valid), 32'(exp_valid));
        check("dual_gap_chid",  32'(chid),  0);
        tick();
        exp_valid = ~exp_valid;
        check("dual_t1_valid", 32'(valid), 32'(exp_valid));
        check("dual_t1_chid",  32'(chid),  3);
        check("dual_t1_data",  32'(data),  32'(ts_exp));
        tick_n(20);
        check("dual_idle", 32'(busy), 0);

        // ---- overflow: ch1 twice during ch0 hold ----
        trig[0] = 1'b1;
        tick_n(4);
        exp_valid = ~exp_valid;
        check("ovf_ch0_valid", 32'(valid), 32'(exp_valid));
        check("ovf_ch0_chid",  32'(chid),  0);
        trig[0] = 1'b0;
        ts_exp  = exp_cnt + 8'd2;
        trig[1] = 1'b1; tick_n(2);
        trig[1] = 1'b0; tick_n(2);
        trig[1] = 1'b1; tick_n(2);
        trig[1] = 1'b0; tick_n(2);
        check("ovf_set", 32'(ovf), 2);
        tick_n(8);
        check("ovf_ch1_wait", 32'(valid), 32'(exp_valid));
        tick();
        exp_valid = ~exp_valid;
        check("ovf_ch1_valid", 32'(valid), 32'(exp_valid));
        check("ovf_ch1_chid",  32'(chid),  1);
        check("ovf_ch1_data",  32'(data),  32'(ts_exp));
        tick_n(25);
        check("ovf_no_third", 32'(valid), 32'(exp_valid));
        check("ovf_sticky",   32'(ovf),   2);
        check("ovf_idle",     32'(busy),  0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ovf), 0);

        // ---- disabled: trigger ignored, counter frozen ----
        en      = 1'b0;
        trig[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dis_busy_hi", 32'(busy), 0);
        end
        trig[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("dis_busy_lo", 32'(busy), 0);
        end
        check("dis_no_toggle", 32'(valid), 32'(exp_valid));
        en      = 1'b1;
        ts_exp  = exp_cnt + 8'd2;
        trig[0] = 1'b1;
        tick_n(4);
        exp_valid = ~exp_valid;
        check("dis_after_valid", 32'(valid), 32'(exp_valid));
        check("dis_after_data",  32'(data),  32'(ts_exp));
        trig[0] = 1'b0;
        tick_n(20);

        // ---- counter near max: wrap or saturate ----
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        wait_cnt(8'hFD);
        tick_n(3);
        trig[3] = 1'b1;
        tick_n(4);
        exp_valid = ~exp_valid;
        check("max_valid", 32'(valid), 32'(exp_valid));
        check("max_chid",  32'(chid),  3);
`ifdef TS_TX_SATURATE_EN
        check("max_data_sat",  32'(data), 32'hFF);
`else
        check("max_data_wrap", 32'(data), 32'h02);
`endif
        trig[3] = 1'b0;
        tick_n(20);

        // ---- reset during HOLD with ch1 pending ----
        trig[0] = 1'b1;
        tick_n(4);
        exp_valid = ~exp_valid;
        check("rh_ch0_valid", 32'(valid), 32'(exp_valid));
        trig[0] = 1'b0;
        trig[1] = 1'b1;
        tick_n(4);
        trig[1] = 1'b0;
        check("rh_busy", 32'(busy), 1);
        rst_ni    = 1'b0;
        exp_cnt   = '0;
        exp_valid = 1'b0;
        #1;
        check("rh_valid", 32'(valid), 0);
        check("rh_chid",  32'(chid),  0);
        check("rh_data",  32'(data),  0);
        check("rh_ovf",   32'(ovf),   0);
        check("rh_busyz", 32'(busy),  0);
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            check("rh_quiet", 32'(valid), 0);
        end
        check("rh_quiet_busy", 32'(busy), 0);
        ts_exp  = exp_cnt + 8'd2;
        trig[2] = 1'b1;
        tick_n(4);
        check("rh_new_valid", 32'(valid), 1);
        check("rh_new_chid",  32'(chid),  2);
        check("rh_new_data",  32'(data),  32'(ts_exp));
        trig[2] = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/udma_ts_event_tx.md
UDMA_TS_EVENT_TX -- requirements
Module: udma_ts_event_tx

Interface
REQ-001 SHALL have parameter NB_CH, default 4, meaning the number of trigger channels (1..2^TS_CHID_WIDTH).
REQ-002 SHALL have parameter TS_DATA_WIDTH, default 28, meaning the timestamp counter and ts_data_o width.
REQ-003 SHALL have parameter TS_CHID_WIDTH, default 4, meaning the channel-ID field width.
REQ-004 SHALL have parameter HOLD_CYCLES, default 16, meaning the minimum number of ts_clk_i cycles (>=8) that data stays stable after each toggle.
REQ-005 SHALL have port ts_clk_i, input, 1 bit: the block clock.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low; the block clock is ts_clk_i.
REQ-007 SHALL have port en_i, input, 1 bit: counter-enable and trigger-enable level.
REQ-008 SHALL have port cnt_clr_i, input, 1 bit: synchronous timestamp counter clear.
REQ-009 SHALL have port trig_async_i, input, NB_CH bits: asynchronous event inputs, one per channel.
REQ-010 SHALL have port ts_valid_async_o, output, 1 bit: toggle-encoded event strobe to the receiver.
REQ-011 SHALL have port ts_chid_o, output, TS_CHID_WIDTH bits: channel ID of the current event.
REQ-012 SHALL have port ts_data_o, output, TS_DATA_WIDTH bits: timestamp of the current event.
REQ-013 SHALL have port ovf_o, output, NB_CH bits: sticky per-channel event-dropped flags.
REQ-014 SHALL have port ovf_clr_i, input, 1 bit: clears all ovf_o bits.
REQ-015 SHALL have port busy_o, output, 1 bit: high while the FSM is not IDLE or any channel is pending.

Function
REQ-016 SHALL keep the timestamp counter (TS_DATA_WIDTH bits) incrementing by 1 per cycle while en_i=1, holding it while en_i=0, and wrapping from all-ones to 0.
REQ-017 SHALL make cnt_clr_i force the counter to 0 on the next cycle, taking priority over the increment.
REQ-018 SHALL pass each trig_async_i bit through a 2-FF synchronizer plus one history FF, and detect a rising edge as sync[1]&~sync[2].
REQ-019 SHALL, on a rising edge in cycle C with en_i=1, set that channel's pending flag and capture the counter value of cycle C into that channel's capture register at the edge ending C.
REQ-020 SHALL ignore rising edges while en_i=0.
REQ-021 SHALL, on a rising edge while the channel is already pending and not being granted that cycle, drop the new event, keep the old capture, and set ovf_o[ch].
REQ-022 SHALL, on a rising edge in the same cycle the channel is granted, capture the new event and set pending with no overflow.
REQ-023 SHALL implement the FSM IDLE -> HOLD -> IDLE.
REQ-024 SHALL, in IDLE with any pending channel, grant the lowest-index pending channel and at the next edge: invert ts_valid_async_o, load ts_data_o/ts_chid_o from the grant, clear its pending flag, load the hold counter with HOLD_CYCLES-1, and enter HOLD.
REQ-025 SHALL, in HOLD, decrement the hold counter each cycle and return to IDLE when it is 0, so consecutive toggles are at least HOLD_CYCLES+1 cycles apart.
REQ-026 SHALL change ts_data_o and ts_chid_o only in the same cycle as a toggle.
REQ-027 SHALL set the latency from trigger edge-detect cycle C to toggle at C+2 when IDLE and no lower-index channel is pending.
REQ-028 SHALL clear all ovf_o bits on ovf_clr_i, with a set in the same cycle winning over the clear.
REQ-029 SHALL NOT let en_i=0 abort a pending event or a HOLD.

Reset
REQ-030 SHALL, while rst_ni=0, drive ts_valid_async_o=0, ts_chid_o=0, ts_data_o=0, ovf_o=0, busy_o=0, the counter to 0, pending flags and captures to 0, synchronizers to 0, and the FSM to IDLE.
REQ-031 SHALL discard a reset asserted mid-HOLD or with events pending without emitting a toggle; the receiver, also reset by rst_ni, sees no edge.

Configuration
REQ-032 SHALL, when the macro TS_TX_SATURATE_EN is defined, make the counter saturate at all-ones instead of wrapping; cnt_clr_i still clears it.
REQ-033 SHALL, when TS_TX_SATURATE_EN is undefined, make the counter wrap as in REQ-016.

Verification
REQ-034 SHALL verify: en_i=1, counter at 100, trig ch2 rises -> one toggle, ts_chid_o=2, ts_data_o = counter value at edge-detect cycle, toggle at C+2.
REQ-035 SHALL verify: ch0 and ch3 rise in the same cycle -> ch0 toggle first, ch3 toggle exactly HOLD_CYCLES+1 cycles later, both with the same timestamp.
REQ-036 SHALL verify: ch1 rises twice within the hold of a prior ch0 event -> second ch1 event dropped, ovf_o=4'b0010, ovf_clr_i pulse -> 0.
REQ-037 SHALL verify: counter preset near max (all-ones minus 2), run 5 cycles -> wraps to 2 without the macro, holds all-ones with TS_TX_SATURATE_EN.
REQ-038 SHALL verify: rst_ni asserted during HOLD with ch1 pending -> all outputs 0 immediately, no toggle after release until a new trigger arrives.
REQ-039 SHALL verify: en_i=0, trig ch0 pulses -> no toggle, busy_o stays 0, counter frozen.
